downcounter_m: RTL and testbench
================================

Name: downcounter_m

Overview:
- Loadable down-counter / interval timer; the count-down counterpart to the team's loadable up-counter (counter_m).
- Loaded with a period, it decrements on enabled cycles and flags terminal count with a one-cycle tc pulse.
- Optional auto-reload gives a periodic tick.
- Sits beside counter_m in the timing/control subsystem as the timeout and tick generator.

Parameters:
WIDTH, 5, width of data, count and internal period register.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
load  input  1  load data into count and period; captures reload mode.
data  input  WIDTH  period value loaded when load=1.
reload  input  1  auto-reload mode; sampled only when load=1.
enable  input  1  decrement qualifier while running.
count  output  WIDTH  current count value (registered).
busy  output  1  1 while state=RUN.
zero  output  1  1 when count==0 (combinational decode of count register).
tc  output  1  registered terminal-count pulse, exactly one cycle.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. No asynchronous reset anywhere.
- Priority at each rising edge: rst > load > enable decrement > hold.
- Reset (rst=1 at edge):
  - count=0, period=0, mode=0, state=IDLE.
  - busy=0, tc=0, zero=1.
  - load and enable are ignored in that cycle.
- States (package enum): IDLE, RUN.
- load=1, in any state:
  - count<=data, period<=data, mode<=reload, tc<=0.
  - If data!=0, next state RUN; if data==0, next state IDLE.
  - A load wins over a coincident terminal event: no tc is produced.
- RUN, enable=0: count, state and mode hold; tc<=0.
- RUN, enable=1, count>1: count<=count-1; tc<=0.
- RUN, enable=1, count==1 (terminal event): tc<=1 for exactly the next cycle.
  - mode=0: count<=0, state<=IDLE.
  - mode=1: count<=period, state stays RUN.
- IDLE without load: count holds (0 after expiry); tc<=0; enable is ignored.
- Latency: load or decrement is visible on count one edge later. tc is high in the same cycle count shows 0 (mode=0) or the reloaded period (mode=1).
- tc is never high for two consecutive cycles, except when mode=1 with period=1 and enable is held high; tc is then high on every enabled cycle.
- reload changes while in RUN have no effect until the next load.
- Arithmetic:
  - Unsigned WIDTH-bit.
  - Maximum period is 2**WIDTH-1.
  - Count never underflows; no wrap below 0 is possible.
- rst mid-run: immediate return to the reset values on that edge. Any pending tc is dropped.

Decomposition:
- Shared package counter_pkg:
  - state_e enum {IDLE, RUN}.
  - Default WIDTH localparam, shared with counter_m.
- Single module; no sub-module warranted.
- period/mode register and next-state logic live in one always_ff and one always_comb.

Test Plan:
- Reset: rst=1 for one cycle, then rst=0 with load=0 -> count=0, zero=1, busy=0, tc=0; count stays 0 for 3 cycles with enable=1.
- One-shot: load=1, data=3, reload=0, then enable=1 -> count 3,2,1,0; tc=1 only in the cycle count=0; busy falls with it; count holds 0 for 2 more cycles.
- Auto-reload: load=1, data=2, reload=1, enable=1 held -> count 2,1,2,1,2; tc=1 in each cycle count returns to 2; busy stays 1.
- Enable gating plus max value: load data=31, then enable pattern 1,0,1,1 -> count 31,30,30,29,28; tc=0 throughout.
- Collision: count=1, enable=1, load=1, data=29 on the same edge -> count=29, tc=0, busy=1. Then load data=0 -> count=0, busy=0, tc=0.
- rst mid-run: count=17 running with load=1, data=5 on the same edge as rst=1 -> count=0, IDLE, tc=0; the following enables do not move count.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ==========================================================================
// counter_pkg : shared types and defaults for counter_m / downcounter_m
// Rev 1.0
// ==========================================================================
package counter_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/downcounter_m.sv
`default_nettype none
// ==========================================================================
// downcounter_m : loadable down-counter / interval timer with auto-reload
// Rev 1.0
// ==========================================================================
module downcounter_m
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             reload,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             tc
);

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_period, w_period_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_tc, w_tc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_count  <= C_ZERO;
      r_period <= C_ZERO;
      r_mode   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_period <= w_period_nxt;
      r_mode   <= w_mode_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_period_nxt = r_period;
    w_mode_nxt   = r_mode;
    w_tc_nxt     = 1'b0;

    // load outranks a coincident terminal event, so no tc is raised then
    if (load) begin
      w_count_nxt  = data;
      w_period_nxt = data;
      w_mode_nxt   = reload;
      w_state_nxt  = (data != C_ZERO) ? RUN : IDLE;
    end else if (r_state == RUN && enable) begin
      if (r_count == C_ONE) begin
        w_tc_nxt = 1'b1;
        if (r_mode) begin
          w_count_nxt = r_period;
        end else begin
          w_count_nxt = C_ZERO;
          w_state_nxt = IDLE;
        end
      end else if (r_count != C_ZERO) begin
        w_count_nxt = r_count - C_ONE;
      end
    end
  end

  assign count = r_count;
  assign busy  = (r_state == RUN);
  assign zero  = (r_count == C_ZERO);
  assign tc    = r_tc;

endmodule : downcounter_m
`default_nettype wire

// File: tb/tb_downcounter_m.sv
`default_nettype none
// ==========================================================================
// tb_downcounter_m : directed self-checking bench for downcounter_m
// Rev 1.0
// ==========================================================================
module tb_downcounter_m;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             reload;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             tc;

  int n_checks = 0;
  int n_fail   = 0;

  downcounter_m #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .data   (data),
    .reload (reload),
    .enable (enable),
    .count  (count),
    .busy   (busy),
    .zero   (zero),
    .tc     (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int c, input int b,
                            input int z, input int t);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".busy"},  int'(busy),  b);
    check({tag, ".zero"},  int'(zero),  z);
    check({tag, ".tc"},    int'(tc),    t);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; reload = 1'b0; enable = 1'b0;

    // reset
    tick();
    expect_all("reset", 0, 0, 1, 0);
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all("idle_hold", 0, 0, 1, 0);
    end

    // one-shot from 3
    load = 1'b1; data = 5'd3; reload = 1'b0; enable = 1'b0;
    tick();
    expect_all("os_load", 3, 1, 0, 0);
    load = 1'b0; enable = 1'b1;
    tick(); expect_all("os_2", 2, 1, 0, 0);
    tick(); expect_all("os_1", 1, 1, 0, 0);
    tick(); expect_all("os_0", 0, 0, 1, 1);
    tick(); expect_all("os_hold0", 0, 0, 1, 0);
    tick(); expect_all("os_hold1", 0, 0, 1, 0);

    // auto-reload with period 2
    load = 1'b1; data = 5'd2; reload = 1'b1; enable = 1'b1;
    tick(); expect_all("ar_load", 2, 1, 0, 0);
    load = 1'b0; reload = 1'b0;
    tick(); expect_all("ar_1a", 1, 1, 0, 0);
    tick(); expect_all("ar_2a", 2, 1, 0, 1);
    tick(); expect_all("ar_1b", 1, 1, 0, 0);
    tick(); expect_all("ar_2b", 2, 1, 0, 1);

    // max period with enable gating 1,0,1,1
    load = 1'b1; data = 5'd31; reload = 1'b0; enable = 1'b0;
    tick(); expect_all("max_load", 31, 1, 0, 0);
    load = 1'b0;
    enable = 1'b1; tick(); expect_all("gate_e1", 30, 1, 0, 0);
    enable = 1'b0; tick(); expect_all("gate_e0", 30, 1, 0, 0);
    enable = 1'b1; tick(); expect_all("gate_e1b", 29, 1, 0, 0);
    tick(); expect_all("gate_e1c", 28, 1, 0, 0);

    // load colliding with a terminal event
    load = 1'b1; data = 5'd1; enable = 1'b0;
    tick(); expect_all("col_pre", 1, 1, 0, 0);
    load = 1'b1; data = 5'd29; enable = 1'b1;
    tick(); expect_all("col_load", 29, 1, 0, 0);
    load = 1'b1; data = 5'd0;
    tick(); expect_all("load_zero", 0, 0, 1, 0);

    // period 1 with reload: tc on every enabled cycle
    load = 1'b1; data = 5'd1; reload = 1'b1; enable = 1'b1;
    tick(); expect_all("p1_load", 1, 1, 0, 0);
    load = 1'b0;
    tick(); expect_all("p1_tc_a", 1, 1, 0, 1);
    tick(); expect_all("p1_tc_b", 1, 1, 0, 1);

    // reset mid-run with coincident load
    load = 1'b1; data = 5'd17; reload = 1'b0; enable = 1'b0;
    tick(); expect_all("rr_load", 17, 1, 0, 0);
    rst = 1'b1; load = 1'b1; data = 5'd5; enable = 1'b1;
    tick(); expect_all("rr_rst", 0, 0, 1, 0);
    rst = 1'b0; load = 1'b0;
    tick(); expect_all("rr_idle_a", 0, 0, 1, 0);
    tick(); expect_all("rr_idle_b", 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_downcounter_m
`default_nettype wire
